// File: rtl/feature_asm_pkg.sv
// Shared widths and types for the feature assembler slice.
// Optional flush support is enabled with FEATURE_ASM_FLUSH_EN.
package feature_asm_pkg;

    localparam int BEAT_W        = 64;
    localparam int FEATURE_LENTH = 9;

    typedef logic [BEAT_W-1:0] beat_t;
    typedef beat_t [FEATURE_LENTH-1:0] anchor_t;

    // Index width that stays legal for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feature_assembler_if.sv
// Beat-in / anchor-out handshake bundle for feature_assembler.
interface feature_assembler_if
    import feature_asm_pkg::*;
#(
    parameter int DW = BEAT_W,
    parameter int FL = FEATURE_LENTH
) ();

    logic [DW-1:0]    feature_in;
    logic             in_valid;
    logic             in_ready;
    logic [FL*DW-1:0] anchor_out;
    logic             anchor_valid;
    logic             anchor_ready;

    modport master (
        output feature_in, in_valid, anchor_ready,
        input  in_ready, anchor_out, anchor_valid
    );

    modport slave (
        input  feature_in, in_valid, anchor_ready,
        output in_ready, anchor_out, anchor_valid
    );

endinterface

// File: rtl/anchor_fifo.sv
// Anchor storage: DEPTH entries of FL beats, written one slice per beat,
// committed with push and released with pop.
module anchor_fifo
    import feature_asm_pkg::*;
#(
    parameter int DW    = BEAT_W,
    parameter int FL    = FEATURE_LENTH,
    parameter int DEPTH = 2,
    localparam int SW   = idx_w(FL),
    localparam int PW   = idx_w(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SW-1:0]    wr_slice,
    input  logic [DW-1:0]    wr_data,
    input  logic             push,
    input  logic             pop,
    output logic [FL*DW-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [FL-1:0][DW-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage is not reset; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr][wr_slice] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/feature_assembler.sv
// Packs FEATURE_LENTH beats per anchor into a small FIFO for the MLP stage.
// Define FEATURE_ASM_FLUSH_EN to add a flush input that drops a partial anchor.
module feature_assembler
    import feature_asm_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = BEAT_W,
    parameter int FEATURE_LENTH  = 9,
    parameter int ANCHOR_DEPTH   = 2,
    parameter int CNT_WIDTH      = 16,
    localparam int BIW           = idx_w(FEATURE_LENTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef FEATURE_ASM_FLUSH_EN
    input  logic                 flush,
`endif
    feature_assembler_if.slave   bus,
    output logic [BIW-1:0]       beat_idx,
    output logic [CNT_WIDTH-1:0] anchor_cnt
);

    logic alive, full, empty, flush_i;
    logic accept, last, push, pop;

`ifdef FEATURE_ASM_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // alive keeps in_ready low through reset without a path from rst_n.
    assign bus.in_ready     = alive && !full && !flush_i;
    assign bus.anchor_valid = !empty;
    assign accept           = bus.in_valid && bus.in_ready;
    assign last             = (beat_idx == BIW'(FEATURE_LENTH - 1));
    assign push             = accept && last;
    assign pop              = bus.anchor_valid && bus.anchor_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alive      <= 1'b0;
            beat_idx   <= '0;
            anchor_cnt <= '0;
        end else begin
            alive <= 1'b1;
            if (flush_i)
                beat_idx <= '0;
            else if (accept)
                beat_idx <= last ? '0 : beat_idx + BIW'(1);
            if (pop)
                anchor_cnt <= anchor_cnt + CNT_WIDTH'(1);
        end
    end

    anchor_fifo #(
        .DW    (DATA_BUS_WIDTH),
        .FL    (FEATURE_LENTH),
        .DEPTH (ANCHOR_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_slice (beat_idx),
        .wr_data  (bus.feature_in),
        .push     (push),
        .pop      (pop),
        .rd_data  (bus.anchor_out),
        .full     (full),
        .empty    (empty)
    );

endmodule
